// File: rtl/uart_rx_if.sv
// Host-side bundle for the UART receiver: oversample tick, serial line, read strobe and status.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_en;
  logic                 rx;
  logic                 rx_read;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 overrun;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output rx_en, rx, rx_read,
    input  rx_data, rx_valid, overrun, frame_err, busy
  );

  modport slave (
    input  rx_en, rx, rx_read,
    output rx_data, rx_valid, overrun, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver clocked by a 16x oversample tick; holds the last good byte
// for the host and flags framing errors and overruns.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 over_q, over_d;
  logic                 ferr_q, ferr_d;
  logic                 sync1_q, sync2_q;
  logic                 rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
      ferr_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      over_q  <= over_d;
      ferr_q  <= ferr_d;
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    over_d  = over_q;
    ferr_d  = 1'b0;

    if (bus.rx_read) begin
      valid_d = 1'b0;
      over_d  = 1'b0;
    end

    if (bus.rx_en) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            bit_d  = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rx_s) begin
              // A load coinciding with a host read counts as consumed, so no overrun.
              data_d  = shreg_q;
              valid_d = 1'b1;
              if (valid_q && !bus.rx_read) begin
                over_d = 1'b1;
              end
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.overrun   = over_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a byte-level model of the receiver's
// host-visible behaviour; rx_en ticks every 4 clks, 64 clks per bit.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst;
  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int phase = 0;
  int ferrCount = 0;
  logic rxLine = 1'b1;
  logic readLine = 1'b0;

  logic [7:0] mData;
  logic       mValid;
  logic       mOver;
  int         mFerr;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) ferrCount++;
  end

  task automatic applyStimulus();
    @(negedge clk);
    bus.rx_en   = (phase == 0);
    bus.rx      = rxLine;
    bus.rx_read = readLine;
    phase = (phase + 1) % 4;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_data"}, 32'(bus.rx_data), 32'(mData));
    checkOutput({tag, "_valid"}, 32'(bus.rx_valid), 32'(mValid));
    checkOutput({tag, "_overrun"}, 32'(bus.overrun), 32'(mOver));
    checkOutput({tag, "_ferr"}, 32'(ferrCount), 32'(mFerr));
  endtask

  task automatic modelLoad(input logic [7:0] b, input bit readSame);
    if (readSame) mOver = 1'b0;
    else if (mValid) mOver = 1'b1;
    mValid = 1'b1;
    mData  = b;
  endtask

  task automatic modelRead();
    mValid = 1'b0;
    mOver  = 1'b0;
  endtask

  task automatic doRead();
    readLine = 1'b1;
    applyStimulus();
    readLine = 1'b0;
    applyStimulus();
    modelRead();
  endtask

  // Start bit begins two clks before an rx_en tick, so the mid-stop tick
  // lands on step 610 of the frame; readAt selects a read strobe on that step.
  task automatic sendFrame(input logic [7:0] b, input bit goodStop, input int readAt);
    logic [9:0] bits;
    bits = {goodStop, b, 1'b0};
    while (phase != 2) applyStimulus();
    for (int j = 0; j < 640; j++) begin
      rxLine   = bits[j / 64];
      readLine = (j == readAt);
      applyStimulus();
    end
    readLine = 1'b0;
  endtask

  initial begin
    logic [9:0] bits;
    logic [7:0] rb;
    int mode;

    rst = 1'b1;
    bus.rx_en = 1'b0;
    bus.rx = 1'b1;
    bus.rx_read = 1'b0;
    mData = 8'h00;
    mValid = 1'b0;
    mOver = 1'b0;
    mFerr = 0;

    repeat (3) applyStimulus();
    checkAll("reset");
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    repeat (8) applyStimulus();

    sendFrame(8'hA5, 1'b1, -1);
    modelLoad(8'hA5, 1'b0);
    checkAll("t1_a5");
    checkOutput("t1_busy", 32'(bus.busy), 32'd0);

    while (phase != 2) applyStimulus();
    rxLine = 1'b0;
    repeat (16) applyStimulus();
    checkOutput("t2_busy_start", 32'(bus.busy), 32'd1);
    rxLine = 1'b1;
    repeat (48) applyStimulus();
    checkOutput("t2_busy_idle", 32'(bus.busy), 32'd0);
    checkAll("t2_glitch");

    doRead();
    checkAll("t2_read");

    sendFrame(8'h3C, 1'b0, -1);
    rxLine = 1'b0;
    repeat (128) applyStimulus();
    mFerr++;
    checkAll("t3_ferr");
    checkOutput("t3_busy_low", 32'(bus.busy), 32'd1);
    rxLine = 1'b1;
    repeat (64) applyStimulus();
    checkOutput("t3_busy_rel", 32'(bus.busy), 32'd0);
    sendFrame(8'h55, 1'b1, -1);
    modelLoad(8'h55, 1'b0);
    checkAll("t3_55");
    doRead();

    sendFrame(8'h11, 1'b1, -1);
    modelLoad(8'h11, 1'b0);
    sendFrame(8'h22, 1'b1, -1);
    modelLoad(8'h22, 1'b0);
    checkAll("t4_overrun");
    doRead();
    checkAll("t4_read");

    sendFrame(8'h11, 1'b1, -1);
    modelLoad(8'h11, 1'b0);
    sendFrame(8'h22, 1'b1, 610);
    modelLoad(8'h22, 1'b1);
    checkAll("t5_readload");

    bits = {1'b1, 8'hFF, 1'b0};
    while (phase != 2) applyStimulus();
    for (int j = 0; j < 5 * 64 + 32; j++) begin
      rxLine = bits[j / 64];
      applyStimulus();
    end
    checkOutput("t6_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    mData = 8'h00;
    modelRead();
    checkAll("t6_rst");
    checkOutput("t6_busy_rst", 32'(bus.busy), 32'd0);
    rxLine = 1'b1;
    repeat (2) applyStimulus();
    rst = 1'b0;
    repeat (8) applyStimulus();
    sendFrame(8'h81, 1'b1, -1);
    modelLoad(8'h81, 1'b0);
    checkAll("t6_81");

    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      mode = int'($urandom_range(0, 2));
      if (mode == 1) begin
        sendFrame(rb, 1'b1, 610);
        modelLoad(rb, 1'b1);
      end else begin
        sendFrame(rb, 1'b1, -1);
        modelLoad(rb, 1'b0);
      end
      checkAll($sformatf("rnd%0d", i));
      if (mode == 2) begin
        doRead();
        checkAll($sformatf("rnd%0d_read", i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
